// File: rtl/bin_onehot_sequencer.sv
// rtl/bin_onehot_sequencer.sv - handshaked binary-to-one-hot sequencer with hold/gap timing
// and a one-entry pending slot so the next code can be queued while the current one drives.
module bin_onehot_sequencer #(
  parameter int W    = 3,
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [W-1:0]      bin,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [(1<<W)-1:0] dec,
  output logic              busy,
  output logic              done
);

  localparam int N    = 1 << W;
  localparam int MAXC = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_GAP
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   dec_q, dec_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           pend_vld_q, pend_vld_d;
  logic [W-1:0]   pend_bin_q, pend_bin_d;

  logic           accept;
  logic           end_period;
  logic           launch_en;
  logic           consumed;
  logic [W-1:0]   launch_code;

  assign in_ready = ~pend_vld_q;
  assign accept   = in_valid & ~pend_vld_q & ~clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dec_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_bin_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dec_q      <= dec_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pend_vld_q <= pend_vld_d;
      pend_bin_q <= pend_bin_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dec_d       = dec_q;
    busy_d      = busy_q;
    pend_vld_d  = pend_vld_q;
    pend_bin_d  = pend_bin_q;
    end_period  = 1'b0;
    launch_en   = 1'b0;
    consumed    = 1'b0;
    launch_code = bin;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          launch_en = 1'b1;
          consumed  = 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          if (GAP > 0) begin
            state_d = S_GAP;
            dec_d   = '0;
            cnt_d   = GAP_LD;
          end else begin
            end_period = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          end_period = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A pending code always outranks one arriving on the same boundary edge.
    if (end_period) begin
      if (pend_vld_q) begin
        launch_en   = 1'b1;
        launch_code = pend_bin_q;
        pend_vld_d  = 1'b0;
      end else if (accept) begin
        launch_en = 1'b1;
        consumed  = 1'b1;
      end else begin
        state_d = S_IDLE;
        dec_d   = '0;
        busy_d  = 1'b0;
      end
    end

    if (accept && !consumed) begin
      pend_vld_d = 1'b1;
      pend_bin_d = bin;
    end

    if (launch_en) begin
      state_d = S_HOLD;
      dec_d   = N'(1) << launch_code;
      cnt_d   = HOLD_LD;
      busy_d  = 1'b1;
    end

    if (clear) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      dec_d      = '0;
      busy_d     = 1'b0;
      pend_vld_d = 1'b0;
    end

    done_d = (state_d == S_HOLD) && (cnt_d == '0);
  end

  assign dec  = dec_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
